// File: rtl/req_chunk_scheduler.sv
// req_chunk_scheduler: one request slot per requester, each request split into
// CHUNK_BYTES pieces and granted round-robin into a single registered output.
module req_chunk_scheduler #(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned CHUNK_BYTES = 4096,
  parameter  int unsigned META_BITS   = 64,
  parameter  int unsigned LEN_BITS    = 32,
  parameter  int unsigned VADDR_BITS  = 64,
  localparam int unsigned ID_BITS     = $clog2(N_REQ)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_REQ-1:0]              s_valid,
  output logic [N_REQ-1:0]              s_ready,
  input  logic [N_REQ*LEN_BITS-1:0]     s_len,
  input  logic [N_REQ*VADDR_BITS-1:0]   s_vaddr,
  input  logic [N_REQ-1:0]              s_last,
  input  logic [N_REQ*META_BITS-1:0]    s_meta,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [LEN_BITS-1:0]           m_len,
  output logic [VADDR_BITS-1:0]         m_vaddr,
  output logic                          m_last,
  output logic [META_BITS-1:0]          m_meta,
  output logic [ID_BITS-1:0]            m_id
);

  localparam logic [LEN_BITS-1:0]   CHUNK_LEN   = LEN_BITS'(CHUNK_BYTES);
  localparam logic [VADDR_BITS-1:0] CHUNK_VADDR = VADDR_BITS'(CHUNK_BYTES);

  logic [N_REQ-1:0]      occ;
  logic [N_REQ-1:0]      occ_next;
  logic [N_REQ-1:0]      accept;
  logic [LEN_BITS-1:0]   slot_len   [N_REQ];
  logic [VADDR_BITS-1:0] slot_vaddr [N_REQ];
  logic [META_BITS-1:0]  slot_meta  [N_REQ];
  logic [N_REQ-1:0]      slot_last;

  logic [ID_BITS-1:0]    rr_ptr;
  logic [ID_BITS-1:0]    gnt;
  logic [ID_BITS-1:0]    cand_idx;
  logic                  found;
  logic                  load_out;
  logic                  take;
  logic                  gnt_final;

  assign accept = s_valid & s_ready;

  // Search starts one past the last grant; a slot accepted this cycle is not yet occ.
  always_comb begin
    found    = 1'b0;
    gnt      = '0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_idx = ID_BITS'((32'(rr_ptr) + k) % N_REQ);
      if (!found && occ[cand_idx]) begin
        found = 1'b1;
        gnt   = cand_idx;
      end
    end
  end

  assign load_out  = !m_valid || m_ready;
  assign take      = load_out && found;
  assign gnt_final = (slot_len[gnt] <= CHUNK_LEN);

  always_comb begin
    occ_next = occ;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        occ_next[i] = 1'b1;
      end
      if (take && gnt_final && (gnt == ID_BITS'(i))) begin
        occ_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      occ     <= '0;
      s_ready <= '0;
      m_valid <= 1'b0;
      rr_ptr  <= ID_BITS'(N_REQ - 1);
    end else begin
      occ     <= occ_next;
      s_ready <= ~occ_next;
      if (load_out) begin
        m_valid <= found;
      end
      if (take) begin
        rr_ptr <= gnt;
      end
    end
  end

  // Slot payload needs no reset: occ qualifies it.
  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_len[i]   <= s_len[i*LEN_BITS +: LEN_BITS];
        slot_vaddr[i] <= s_vaddr[i*VADDR_BITS +: VADDR_BITS];
        slot_meta[i]  <= s_meta[i*META_BITS +: META_BITS];
        slot_last[i]  <= s_last[i];
      end else if (take && !gnt_final && (gnt == ID_BITS'(i))) begin
        slot_len[i]   <= slot_len[i] - CHUNK_LEN;
        slot_vaddr[i] <= slot_vaddr[i] + CHUNK_VADDR;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (take) begin
      m_id    <= gnt;
      m_vaddr <= slot_vaddr[gnt];
      m_meta  <= slot_meta[gnt];
      if (gnt_final) begin
        m_len  <= slot_len[gnt];
        m_last <= slot_last[gnt];
      end else begin
        m_len  <= CHUNK_LEN;
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_chunk_scheduler.sv
// Self-checking bench for req_chunk_scheduler: directed scenarios plus randomized
// traffic against a per-requester chunk-list scoreboard with a starvation bound.
module tb_req_chunk_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned C  = 256;
  localparam int unsigned MB = 64;
  localparam int unsigned LB = 32;
  localparam int unsigned VB = 48;
  localparam int unsigned IB = $clog2(N);
  localparam int RAND_REQS   = 10000;
  localparam int RAND_LIMIT  = 80000;

  typedef struct packed {
    logic [LB-1:0] len;
    logic [VB-1:0] vaddr;
    logic          last;
    logic [MB-1:0] meta;
  } chunk_t;

  typedef struct {
    logic [IB-1:0] id;
    chunk_t        c;
    int            cyc;
  } obs_t;

  logic              aclk;
  logic              aresetn;
  logic [N-1:0]      s_valid;
  logic [N-1:0]      s_ready;
  logic [N*LB-1:0]   s_len;
  logic [N*VB-1:0]   s_vaddr;
  logic [N-1:0]      s_last;
  logic [N*MB-1:0]   s_meta;
  logic              m_valid;
  logic              m_ready;
  logic [LB-1:0]     m_len;
  logic [VB-1:0]     m_vaddr;
  logic              m_last;
  logic [MB-1:0]     m_meta;
  logic [IB-1:0]     m_id;

  int n_cmp = 0;
  int n_err = 0;
  chunk_t exp_q [N][$];
  obs_t   obs_q [$];

  req_chunk_scheduler #(
    .N_REQ(N), .CHUNK_BYTES(C), .META_BITS(MB), .LEN_BITS(LB), .VADDR_BITS(VB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_len(s_len), .s_vaddr(s_vaddr),
    .s_last(s_last), .s_meta(s_meta),
    .m_valid(m_valid), .m_ready(m_ready), .m_len(m_len), .m_vaddr(m_vaddr),
    .m_last(m_last), .m_meta(m_meta), .m_id(m_id)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic void model_push(input int id, input logic [LB-1:0] len,
                                     input logic [VB-1:0] va, input logic last,
                                     input logic [MB-1:0] meta);
    chunk_t        e;
    logic [LB-1:0] rem;
    logic [VB-1:0] a;
    rem = len;
    a   = va;
    if (len == '0) begin
      e = '{len: '0, vaddr: va, last: last, meta: meta};
      exp_q[id].push_back(e);
      return;
    end
    while (rem != '0) begin
      e.len   = (rem > LB'(C)) ? LB'(C) : rem;
      e.vaddr = a;
      e.last  = (rem <= LB'(C)) ? last : 1'b0;
      e.meta  = meta;
      exp_q[id].push_back(e);
      rem = rem - e.len;
      a   = a + VB'(e.len);
    end
  endfunction

  task automatic post(input int id, input logic [LB-1:0] len, input logic [VB-1:0] va,
                      input logic last, input logic [MB-1:0] meta);
    s_len[id*LB +: LB]   = len;
    s_vaddr[id*VB +: VB] = va;
    s_meta[id*MB +: MB]  = meta;
    s_last[id]           = last;
    s_valid[id]          = 1'b1;
  endtask

  task automatic send(input int id, input logic [LB-1:0] len, input logic [VB-1:0] va,
                      input logic last, input logic [MB-1:0] meta, output bit ok);
    ok = 1'b0;
    @(posedge aclk); #1;
    post(id, len, va, last, meta);
    for (int w = 0; w < 20; w++) begin
      @(negedge aclk);
      if (s_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk); #1;
    s_valid[id] = 1'b0;
  endtask

  task automatic collect(input int n, input int max_cyc);
    obs_t o;
    obs_q.delete();
    for (int cyc = 0; cyc < max_cyc && obs_q.size() < n; cyc++) begin
      @(negedge aclk);
      if (m_valid && m_ready) begin
        o.id  = m_id;
        o.c   = '{len: m_len, vaddr: m_vaddr, last: m_last, meta: m_meta};
        o.cyc = cyc;
        obs_q.push_back(o);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid);
    end
    n_cmp++;
    if (s_ready !== {N{1'b0}}) begin
      n_err++; $display("FAIL reset_s_ready: got %b want %b", s_ready, {N{1'b0}});
    end
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (s_ready !== {N{1'b1}}) begin
      n_err++; $display("FAIL post_reset_s_ready: got %b want %b", s_ready, {N{1'b1}});
    end
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_m_valid: got %b want 0", m_valid);
    end
  endtask

  task automatic test_single();
    logic [MB-1:0] meta;
    chunk_t        e;
    bit            ok;
    meta = {$urandom, $urandom};
    do_reset();
    m_ready = 1'b1;
    send(0, LB'(3*C + 100), VB'('h1000), 1'b1, meta, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_accept: got 0 want 1"); end
    collect(4, 20);
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_err++; $display("FAIL single_count: got %0d want 4", obs_q.size());
    end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      e.len   = (k < 3) ? LB'(C) : LB'(100);
      e.vaddr = VB'('h1000 + k*C);
      e.last  = (k == 3);
      e.meta  = meta;
      n_cmp++;
      if (obs_q[k].c !== e || obs_q[k].id !== IB'(0)) begin
        n_err++;
        $display("FAIL single_chunk%0d: got id=%0d %h want id=0 %h", k, obs_q[k].id, obs_q[k].c, e);
      end
      n_cmp++;
      if (obs_q[k].cyc != k + 1) begin
        n_err++; $display("FAIL single_timing%0d: got cycle %0d want %0d", k, obs_q[k].cyc, k + 1);
      end
    end
    n_cmp++;
    if (s_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL single_ready_back: got %b want 1", s_ready[0]);
    end
    @(negedge aclk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL single_no_extra: got m_valid %b want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [MB-1:0] meta [3];
    chunk_t        e;
    int            id;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      meta[i] = {$urandom, $urandom};
      post(i, LB'(2*C), VB'('h10000 * (i + 1)), 1'b1, meta[i]);
    end
    @(negedge aclk);
    @(posedge aclk); #1;
    s_valid = '0;
    collect(6, 20);
    n_cmp++;
    if (obs_q.size() != 6) begin
      n_err++; $display("FAIL b2b_count: got %0d want 6", obs_q.size());
    end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      id      = k % 3;
      e.len   = LB'(C);
      e.vaddr = VB'('h10000 * (id + 1) + (k / 3) * C);
      e.last  = (k >= 3);
      e.meta  = meta[id];
      n_cmp++;
      if (obs_q[k].id !== IB'(id) || obs_q[k].c !== e) begin
        n_err++;
        $display("FAIL b2b_chunk%0d: got id=%0d %h want id=%0d %h", k, obs_q[k].id, obs_q[k].c, id, e);
      end
      n_cmp++;
      if (obs_q[k].cyc != obs_q[0].cyc + k) begin
        n_err++; $display("FAIL b2b_gap%0d: got cycle %0d want %0d", k, obs_q[k].cyc, obs_q[0].cyc + k);
      end
    end
  endtask

  task automatic test_stall();
    logic [MB-1:0] meta;
    chunk_t        e;
    bit            ok;
    bit            seen;
    meta = {$urandom, $urandom};
    do_reset();
    m_ready = 1'b0;
    send(1, LB'(3*C), VB'('h2000), 1'b0, meta, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_accept: got 0 want 1"); end
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      @(negedge aclk);
      seen = m_valid;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL stall_valid: got m_valid 0 want 1"); end
    e = '{len: LB'(C), vaddr: VB'('h2000), last: 1'b0, meta: meta};
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_id !== IB'(1) ||
          chunk_t'({m_len, m_vaddr, m_last, m_meta}) !== e) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b id=%0d %h want v=1 id=1 %h", k, m_valid, m_id,
                 chunk_t'({m_len, m_vaddr, m_last, m_meta}), e);
      end
    end
    @(posedge aclk); #1;
    m_ready = 1'b1;
    collect(3, 20);
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_err++; $display("FAIL stall_count: got %0d want 3", obs_q.size());
    end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      e.vaddr = VB'('h2000 + k*C);
      n_cmp++;
      if (obs_q[k].id !== IB'(1) || obs_q[k].c !== e) begin
        n_err++;
        $display("FAIL stall_chunk%0d: got id=%0d %h want id=1 %h", k, obs_q[k].id, obs_q[k].c, e);
      end
    end
  endtask

  task automatic test_len_edges();
    logic [MB-1:0] meta;
    chunk_t        e [3];
    int            ids [3];
    bit            ok;
    meta = {$urandom, $urandom};
    do_reset();
    m_ready = 1'b1;
    e[0] = '{len: '0,     vaddr: VB'('h3000), last: 1'b1, meta: meta};
    e[1] = '{len: LB'(C), vaddr: VB'('h4000), last: 1'b0, meta: meta};
    e[2] = '{len: LB'(C), vaddr: VB'('h5000), last: 1'b1, meta: meta};
    ids  = '{3, 2, 2};
    for (int k = 0; k < 3; k++) begin
      send(ids[k], e[k].len, e[k].vaddr, e[k].last, meta, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL edge_accept%0d: got 0 want 1", k); end
      collect(1, 10);
      n_cmp++;
      if (obs_q.size() != 1) begin
        n_err++; $display("FAIL edge_count%0d: got %0d want 1", k, obs_q.size());
      end else if (obs_q[0].id !== IB'(ids[k]) || obs_q[0].c !== e[k]) begin
        n_err++;
        $display("FAIL edge_chunk%0d: got id=%0d %h want id=%0d %h", k, obs_q[0].id, obs_q[0].c, ids[k], e[k]);
      end
    end
    collect(1, 6);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL edge_extra: got %0d chunks want 0", obs_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) post(i, LB'(2*C), VB'('h10000 * (i + 1)), 1'b1, {$urandom, $urandom});
    @(negedge aclk);
    @(posedge aclk); #1;
    s_valid = '0;
    @(negedge aclk);
    @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    n_cmp++;
    if (s_ready !== {N{1'b0}}) begin
      n_err++; $display("FAIL midrst_s_ready: got %b want %b", s_ready, {N{1'b0}});
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (m_valid) stale++;
    end
    n_cmp++;
    if (stale != 0) begin n_err++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
    @(posedge aclk); #1;
    post(2, LB'(C), VB'('h7000), 1'b1, '0);
    post(0, LB'(C), VB'('h6000), 1'b1, '0);
    @(negedge aclk);
    @(posedge aclk); #1;
    s_valid = '0;
    collect(2, 10);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_err++; $display("FAIL midrst_count: got %0d want 2", obs_q.size());
    end else if (obs_q[0].id !== IB'(0) || obs_q[1].id !== IB'(2)) begin
      n_err++; $display("FAIL midrst_order: got %0d,%0d want 0,2", obs_q[0].id, obs_q[1].id);
    end
  endtask

  task automatic test_random();
    int            posted;
    int            accepted;
    int            cyc;
    int            g;
    int            wait_cnt [N];
    int            pending;
    logic [N-1:0]  acc;
    chunk_t        o;
    chunk_t        e;
    logic [LB-1:0] len;
    do_reset();
    posted   = 0;
    accepted = 0;
    cyc      = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    while (cyc < RAND_LIMIT) begin
      @(negedge aclk);
      cyc++;
      if (m_valid && m_ready) begin
        g = int'(m_id);
        o = '{len: m_len, vaddr: m_vaddr, last: m_last, meta: m_meta};
        n_cmp++;
        if (exp_q[g].size() == 0) begin
          n_err++; $display("FAIL rand_unexpected: got id=%0d %h want no chunk", g, o);
        end else begin
          e = exp_q[g].pop_front();
          if (o !== e) begin
            n_err++; $display("FAIL rand_chunk: got id=%0d %h want %h", g, o, e);
          end
        end
        for (int j = 0; j < N; j++) begin
          if (j != g && exp_q[j].size() > 0) begin
            wait_cnt[j]++;
            n_cmp++;
            if (wait_cnt[j] > N) begin
              n_err++; $display("FAIL rand_starve: id %0d waited %0d grants want <= %0d", j, wait_cnt[j], N);
            end
          end
        end
        wait_cnt[g] = 0;
      end
      acc = s_valid & s_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          model_push(i, s_len[i*LB +: LB], s_vaddr[i*VB +: VB], s_last[i], s_meta[i*MB +: MB]);
          accepted++;
        end
      end
      pending = 0;
      for (int i = 0; i < N; i++) pending += exp_q[i].size();
      if (posted == RAND_REQS && (s_valid & ~acc) == '0 && pending == 0) break;
      @(posedge aclk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) s_valid[i] = 1'b0;
        if (!s_valid[i] && posted < RAND_REQS && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 9))
            0:       len = '0;
            1:       len = LB'(C);
            2:       len = LB'(C * $urandom_range(2, 3));
            default: len = LB'($urandom_range(1, 3*C + C/2));
          endcase
          post(i, len, VB'({$urandom, $urandom}), 1'($urandom_range(0, 1)), {$urandom, $urandom});
          posted++;
        end
      end
    end
    n_cmp++;
    if (cyc >= RAND_LIMIT) begin
      n_err++; $display("FAIL rand_timeout: got %0d cycles want < %0d", cyc, RAND_LIMIT);
    end
    n_cmp++;
    if (accepted != RAND_REQS) begin
      n_err++; $display("FAIL rand_accepted: got %0d want %0d", accepted, RAND_REQS);
    end
    s_valid = '0;
  endtask

  initial begin
    aresetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    s_len   = '0;
    s_vaddr = '0;
    s_last  = '0;
    s_meta  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_len_edges();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
